// File: rtl/bin_to_bcd_if.sv
// Handshake bundle for bin_to_bcd: start/operand in, busy/done/BCD result out.
// BIN2BCD_LZ_BLANK_EN adds the leading-zero blanking vector to the bundle.
interface bin_to_bcd_if #(parameter int N = 8);
    // floor(N*log10(2)) + 1 digits for 2^N, plus one spare digit
    localparam int DIGITS = ((N * 1233) >> 12) + 2;
    localparam int W_OUT  = 4 * DIGITS;

    logic             start;
    logic [N-1:0]     data_in;
    logic             busy;
    logic             done;
    logic [W_OUT-1:0] data_out;
`ifdef BIN2BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_n;

    modport master (output start, data_in, input busy, done, data_out, blank_n);
    modport slave  (input start, data_in, output busy, done, data_out, blank_n);
`else
    modport master (output start, data_in, input busy, done, data_out);
    modport slave  (input start, data_in, output busy, done, data_out);
`endif
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Optional BIN2BCD_LZ_BLANK_EN adds a registered leading-zero blank vector.
module bcd_nib_adj (
    input  logic [3:0] nib,
    output logic [3:0] adj
);
    assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module bin_to_bcd #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst,
    bin_to_bcd_if.slave bus
);
    localparam int DIGITS = ((N * 1233) >> 12) + 2;
    localparam int W_OUT  = 4 * DIGITS;
    localparam int CW     = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, next_state;
    logic [N-1:0]     bin_q;
    logic [W_OUT-1:0] bcd_q;
    logic [W_OUT-1:0] bcd_adj;
    logic [W_OUT+N-1:0] shifted;
    logic [CW-1:0]    cnt_q;
    logic [W_OUT-1:0] data_out_q;
    logic             done_q;
    logic             busy_c;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_nib
            bcd_nib_adj u_adj (.nib(bcd_q[4*g +: 4]), .adj(bcd_adj[4*g +: 4]));
        end
    endgenerate

    // Binary MSB walks into BCD bit 0 after the add-3 correction.
    assign shifted = {bcd_adj, bin_q} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state != IDLE);
    end

`ifdef BIN2BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] lz;
    logic [DIGITS-1:0] blank_q;

    always_comb begin
        logic all_zero;
        lz       = '0;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero && (bcd_q[4*k +: 4] == 4'd0);
            lz[k]    = all_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        else if (state == DONE) blank_q <= lz;
    end

    assign bus.blank_n = blank_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bin_q <= bus.data_in;
                    bcd_q <= '0;
                    cnt_q <= CW'(N);
                end
                SHIFT: begin
                    bcd_q <= shifted[W_OUT+N-1:N];
                    bin_q <= shifted[N-1:0];
                    cnt_q <= cnt_q - CW'(1);
                end
                DONE: begin
                    data_out_q <= bcd_q;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd (N=8): vector table, full sweep and corner sequences.
module tb_bin_to_bcd;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bin_to_bcd_if #(.N(N)) bus ();
    bin_to_bcd #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        int          din;
        logic [15:0] exp_out;
        logic [3:0]  exp_blank;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dec_bcd(input int v);
        logic [15:0] r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One conversion from idle: returns result and edges from accept to done.
    task automatic run(input int v, output logic [15:0] res, output int lat, output bit got);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 8'(v);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) got = 1;
        end
        res = bus.data_out;
    endtask

    initial begin
        logic [15:0] res;
        int lat, dones, last_t, n_done, stab_err, interval_err, val_err;
        bit got, prev_busy;
        logic [15:0] held;

        vecs[0]  = '{255, 16'h0255, 4'b1000};
        vecs[1]  = '{99,  16'h0099, 4'b1100};
        vecs[2]  = '{100, 16'h0100, 4'b1000};
        vecs[3]  = '{9,   16'h0009, 4'b1110};
        vecs[4]  = '{0,   16'h0000, 4'b1110};
        vecs[5]  = '{1,   16'h0001, 4'b1110};
        vecs[6]  = '{10,  16'h0010, 4'b1100};
        vecs[7]  = '{128, 16'h0128, 4'b1000};
        vecs[8]  = '{5,   16'h0005, 4'b1110};
        vecs[9]  = '{40,  16'h0040, 4'b1100};
        vecs[10] = '{199, 16'h0199, 4'b1000};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.data_in = '0;
        #12;
        chk("reset_data_out", 32'(bus.data_out), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
`ifdef BIN2BCD_LZ_BLANK_EN
        chk("reset_blank", 32'(bus.blank_n), 32'b1110);
`endif
        @(negedge clk);
        rst = 1'b0;

        // first conversion: latency and busy behaviour
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_in = 8'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'h1);
        lat = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) got = 1;
        end
        chk("zero_done_seen", 32'(got), 32'h1);
        chk("zero_latency", 32'(lat), 32'(N + 1));
        chk("zero_result", 32'(bus.data_out), 32'h0);
        chk("zero_busy_in_done", 32'(bus.busy), 32'h0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done), 32'h0);

        for (int i = 0; i < 11; i++) begin
            run(vecs[i].din, res, lat, got);
            chk($sformatf("vec%0d_done", i), 32'(got), 32'h1);
            chk($sformatf("vec%0d_out_%0d", i, vecs[i].din), 32'(res), 32'(vecs[i].exp_out));
`ifdef BIN2BCD_LZ_BLANK_EN
            chk($sformatf("vec%0d_blank_%0d", i, vecs[i].din), 32'(bus.blank_n), 32'(vecs[i].exp_blank));
`endif
        end

        for (int v = 0; v < 256; v++) begin
            run(v, res, lat, got);
            chk($sformatf("sweep_%0d", v), {got, 15'd0, res}, {1'b1, 15'd0, dec_bcd(v)});
        end

        // start pulse and operand change during busy must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_in = 8'd200;
        @(negedge clk);
        bus.data_in = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data_in = 8'hAA;
        dones = 0; res = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin dones++; res = bus.data_out; end
        end
        chk("ignore_done_count", 32'(dones), 32'h1);
        chk("ignore_result", 32'(res), 32'h0200);

        // reset mid-conversion aborts at once
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_in = 8'd123;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_data_out", 32'(bus.data_out), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'h0);
        run(45, res, lat, got);
        chk("after_abort_45", {got, 15'd0, res}, {1'b1, 15'd0, 16'h0045});

        // back-to-back with start held high, operand alternating 1 / 254
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_in = 8'd1;
        prev_busy = 1'b0;
        n_done = 0; last_t = 0; stab_err = 0; interval_err = 0; val_err = 0;
        held = bus.data_out;
        for (int t = 1; t < 100 && n_done < 6; t++) begin
            @(posedge clk); #1;
            if (bus.busy && !prev_busy) bus.data_in = (bus.data_in == 8'd1) ? 8'd254 : 8'd1;
            prev_busy = bus.busy;
            if (bus.done) begin
                if (bus.data_out !== ((n_done % 2 == 0) ? 16'h0001 : 16'h0254)) val_err++;
                if (n_done > 0 && t - last_t != N + 2) interval_err++;
                last_t = t;
                n_done++;
                held = bus.data_out;
            end else if (bus.data_out !== held) begin
                stab_err++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_done_count", 32'(n_done), 32'd6);
        chk("b2b_values", 32'(val_err), 32'd0);
        chk("b2b_interval", 32'(interval_err), 32'd0);
        chk("b2b_stable", 32'(stab_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It accepts an N-bit unsigned binary value and produces a packed BCD result, one decimal digit per nibble. The result carries one spare most-significant digit beyond what 2^N strictly needs. It sits between binary datapath logic and decimal display or formatting logic.

Parameters:
N, 8, binary input width in bits (N ≥ 1).
DIGITS, derived localparam = ceil(log10(2^N)) + 1, number of BCD digits in the output (4 for N=8).
W_OUT, derived localparam = 4*DIGITS, output width in bits (16 for N=8).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  conversion request; sampled on a rising edge while idle.
data_in  input  N  unsigned binary operand; captured on the accepted-start edge.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when data_out has just been updated.
data_out  output  W_OUT  packed BCD result; nibble k is decimal digit 10^k (nibble 0 = LSBs).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: data_out = 0, done = 0, busy = 0, FSM = IDLE, internal shift and count registers = 0.
- FSM states are IDLE, SHIFT, and DONE.
- IDLE:
  - On an edge with start=1, latch data_in into the binary shift register.
  - Clear the BCD working register (W_OUT bits).
  - Set the iteration count to N and go to SHIFT. busy rises on that same edge.
- SHIFT (exactly N cycles):
  - Each cycle, first add 3 to every working BCD nibble whose value is ≥ 5.
  - Then shift the concatenation {BCD, binary} left by 1, so the binary MSB enters BCD bit 0.
  - Decrement the count. When the count reaches 0 after the Nth shift, go to DONE.
- DONE:
  - Copy the working BCD register to data_out.
  - Assert done for exactly one cycle, deassert busy, and return to IDLE.
- Latency:
  - done is high in the cycle that begins N+1 rising edges after the accepted start edge (9 edges for N=8).
  - A new start is accepted in the cycle done is high, so back-to-back throughput is one conversion per N+2 cycles.
- start while busy=1 is ignored; it is neither queued nor able to corrupt the in-flight operand.
- data_in is only sampled on the accepted start edge; later changes do not affect the result.
- data_out holds its last result between conversions and changes only in the done cycle.
- Arithmetic:
  - Every output nibble is 0..9.
  - The top (spare) nibble is always 0, since 2^N−1 fits in DIGITS−1 digits.
  - The result must equal the decimal representation of data_in for all 2^N inputs.
- Reset asserted mid-conversion aborts immediately to the reset values; no done pulse is issued for the aborted conversion.

Optional Feature:
BIN2BCD_LZ_BLANK_EN
- Defined: add output blank_n [DIGITS-1:0], registered and updated together with data_out.
  - Bit k = 1 when digit k is a leading zero (it and all higher digits are 0) and k > 0.
  - Digit 0 is never blanked. Reset value is all ones except bit 0, which is 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with data_in=0 -> done after N+1 edges, data_out=16'h0000, busy low afterwards.
- Sweep data_in 0..255, one start per done -> each data_out equals the decimal value (e.g. 255 -> 16'h0255, 99 -> 16'h0099, 100 -> 16'h0100, 9 -> 16'h0009); top nibble always 0.
- Start with 200, then pulse start with 7 and change data_in during busy -> single done with data_out=16'h0200; no second done.
- Start with 123, assert rst after 4 cycles -> outputs 0 immediately, no done; after release, start with 45 -> 16'h0045.
- Back-to-back: start held high continuously with data_in alternating 1/254 -> done every N+2 cycles with 16'h0001 / 16'h0254, and data_out stable between dones.
- With BIN2BCD_LZ_BLANK_EN: input 5 -> blank_n=4'b1110; input 40 -> 4'b1100; input 0 -> 4'b1110.
